// File: rtl/alu_result_select.sv
// Registered result selector at the ALU output: captures one functional-unit
// result on its completion strobe and holds it under a valid/ready handshake.

module alu_result_select_lane #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 4,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] chData,
  input  logic             chDone,
  input  logic [SEL_W-1:0] curSel,
  output logic [WIDTH-1:0] mData,
  output logic             mDone
);
  logic hit;

  assign hit   = (curSel == SEL_W'(IDX));
  assign mData = hit ? chData : '0;
  assign mDone = hit & chDone;
endmodule

module alu_result_select #(
  parameter int WIDTH   = 64,
  parameter int N_IN    = 16,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [N_IN-1:0]       in_done,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  busy,
  output logic                  err_sel,
  output logic                  err_timeout
);
  localparam int CNT_W = (TIMEOUT <= 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT <= 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t             state, stateNxt;
  logic [WIDTH-1:0]   dataQ, dataNxt;
  logic [SEL_W-1:0]   selQ, selNxt;
  logic               errSelQ, errSelNxt;
  logic               errToQ, errToNxt;
  logic [CNT_W-1:0]   cnt, cntNxt;

  logic [SEL_W-1:0]             curSel;
  logic [N_IN-1:0][WIDTH-1:0]   laneData;
  logic [N_IN-1:0]              laneDone;
  logic [WIDTH-1:0]             pickData;
  logic                         pickDone;
  logic                         selInRange;
  logic                         acceptStart;

  // While waiting, the mux follows the latched code; otherwise it follows the
  // live code so a start can use a unit that is already done this cycle.
  assign curSel     = (state == WAIT) ? selQ : sel;
  assign selInRange = ({1'b0, curSel} < (SEL_W+1)'(N_IN));

  for (genvar i = 0; i < N_IN; i++) begin : gLane
    alu_result_select_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (i)
    ) uLane (
      .chData (in_bus[i*WIDTH +: WIDTH]),
      .chDone (in_done[i]),
      .curSel (curSel),
      .mData  (laneData[i]),
      .mDone  (laneDone[i])
    );
  end

  always_comb begin
    pickData = '0;
    pickDone = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      pickData = pickData | laneData[i];
      pickDone = pickDone | laneDone[i];
    end
  end

  assign acceptStart = start & ((state == IDLE) | ((state == DONE) & out_ready));

  always_comb begin
    stateNxt  = state;
    dataNxt   = dataQ;
    selNxt    = selQ;
    errSelNxt = errSelQ;
    errToNxt  = errToQ;
    cntNxt    = cnt;

    case (state)
      IDLE: ;
      WAIT: begin
        if (pickDone) begin
          dataNxt  = pickData;
          stateNxt = DONE;
        end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
          dataNxt  = '0;
          errToNxt = 1'b1;
          stateNxt = DONE;
        end else if (cnt != CNT_MAX) begin
          cntNxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase

    // A start accepted in IDLE or alongside a DONE handshake overrides the above.
    if (acceptStart) begin
      selNxt    = sel;
      cntNxt    = '0;
      errSelNxt = 1'b0;
      errToNxt  = 1'b0;
      if (!selInRange) begin
        dataNxt   = '0;
        errSelNxt = 1'b1;
        stateNxt  = DONE;
      end else if (pickDone) begin
        dataNxt  = pickData;
        stateNxt = DONE;
      end else begin
        stateNxt = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dataQ   <= '0;
      selQ    <= '0;
      errSelQ <= 1'b0;
      errToQ  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= stateNxt;
      dataQ   <= dataNxt;
      selQ    <= selNxt;
      errSelQ <= errSelNxt;
      errToQ  <= errToNxt;
      cnt     <= cntNxt;
    end
  end

  assign out_data    = dataQ;
  assign out_sel     = selQ;
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign err_sel     = errSelQ;
  assign err_timeout = errToQ;
endmodule
